// File: rtl/traffic_pkg.sv
// Shared light codes, FSM state codes and decode helpers for the
// four-approach intersection arbiter.
package traffic_pkg;

  localparam int NUM_APP = 4;

  typedef enum logic [1:0] {
    LT_RED    = 2'd0,
    LT_YELLOW = 2'd1,
    LT_GREEN  = 2'd2
  } light_e;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  // Only the owning approach shows a non-RED code; ALLRED shows RED everywhere.
  function automatic logic [2*NUM_APP-1:0] light_vec(input state_e st, input logic [1:0] idx);
    logic [2*NUM_APP-1:0] v;
    light_e code;
    v = {(2*NUM_APP){1'b0}};
    case (st)
      ST_GREEN:  code = LT_GREEN;
      ST_YELLOW: code = LT_YELLOW;
      default:   code = LT_RED;
    endcase
    for (int i = 0; i < NUM_APP; i++) begin
      if (i == int'(idx)) begin
        v[2*i +: 2] = code;
      end else begin
        v[2*i +: 2] = LT_RED;
      end
    end
    return v;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_APP-1:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin selector: first pending approach searching upward from
// current+1 (wrapping), returned one-hot; all-zero when nothing is pending.
module rr_pick4
  import traffic_pkg::*;
(
  input  logic [NUM_APP-1:0] pending,
  input  logic [1:0]         current,
  output logic [NUM_APP-1:0] next_oh
);

  logic [NUM_APP-1:0] rot_s;
  logic [NUM_APP-1:0] sel_s;

  // Rotate so the search origin is bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_s   = 4'b0000;
    next_oh = 4'b0000;
    for (int i = 0; i < NUM_APP; i++) begin
      rot_s[i] = pending[2'(i + int'(current) + 1)];
    end
    casez (rot_s)
      4'b???1: sel_s = 4'b0001;
      4'b??10: sel_s = 4'b0010;
      4'b?100: sel_s = 4'b0100;
      4'b1000: sel_s = 4'b1000;
      default: sel_s = 4'b0000;
    endcase
    for (int i = 0; i < NUM_APP; i++) begin
      next_oh[2'(i + int'(current) + 1)] = sel_s[i];
    end
  end

endmodule

// File: rtl/light_phase_arbiter.sv
// Four-approach traffic light arbiter: GREEN -> YELLOW -> ALLRED cycle with
// min/max green timing, latched requests and round-robin hand-over.
module light_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic [NUM_APP-1:0]     req,
  output logic [2*NUM_APP-1:0]   lights,
  output logic [NUM_APP-1:0]     grant,
  output logic [1:0]             phase
);

  localparam int TMAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
  localparam int CW     = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] CNT_0   = CW'(0);
  localparam logic [CW-1:0] CNT_1   = CW'(1);

  state_e               state_r, state_n_s;
  logic [1:0]           cur_r, cur_n_s;
  logic [1:0]           next_r, next_n_s;
  logic [CW-1:0]        count_r, count_n_s;
  logic [NUM_APP-1:0]   pending_r, pending_n_s;
  logic [2*NUM_APP-1:0] lights_r, lights_n_s;
  logic [NUM_APP-1:0]   grant_r, grant_n_s;
  logic [1:0]           phase_r, phase_n_s;
  logic [NUM_APP-1:0]   cur_oh_s, others_s, pick_s;

  assign cur_oh_s = 4'b0001 << cur_r;
  assign others_s = pending_r & ~cur_oh_s;

  rr_pick4 u_pick (
    .pending (others_s),
    .current (cur_r),
    .next_oh (pick_s)
  );

  // Next-state, counter, request latching and registered-output decode.
  always_comb begin
    state_n_s   = state_r;
    cur_n_s     = cur_r;
    next_n_s    = next_r;
    count_n_s   = count_r;
    pending_n_s = pending_r | req;
    case (state_r)
      ST_GREEN: begin
        // The approach holding GREEN never latches its own request.
        pending_n_s = pending_r | (req & ~cur_oh_s);
        if ((|others_s) &&
            (((count_r >= GMIN_M1) && !req[cur_r]) || (count_r == GMAX_M1))) begin
          state_n_s = ST_YELLOW;
          count_n_s = CNT_0;
          next_n_s  = onehot_to_idx(pick_s);
        end else if (count_r == GMAX_M1) begin
          count_n_s = count_r;
        end else begin
          count_n_s = count_r + CNT_1;
        end
      end
      ST_YELLOW: begin
        if (count_r == YEL_M1) begin
          state_n_s = ST_ALLRED;
          count_n_s = CNT_0;
        end else begin
          count_n_s = count_r + CNT_1;
        end
      end
      ST_ALLRED: begin
        if (count_r == AR_M1) begin
          state_n_s   = ST_GREEN;
          count_n_s   = CNT_0;
          cur_n_s     = next_r;
          pending_n_s = pending_n_s & ~(4'b0001 << next_r);
        end else begin
          count_n_s = count_r + CNT_1;
        end
      end
      default: begin
        state_n_s   = ST_GREEN;
        cur_n_s     = 2'd0;
        next_n_s    = 2'd0;
        count_n_s   = CNT_0;
        pending_n_s = 4'b0000;
      end
    endcase
    lights_n_s = light_vec(state_n_s, cur_n_s);
    grant_n_s  = (state_n_s == ST_ALLRED) ? 4'b0000 : (4'b0001 << cur_n_s);
    phase_n_s  = state_n_s;
  end

  // State, counters and output registers; reset lands on approach 0 GREEN.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r   <= ST_GREEN;
      cur_r     <= 2'd0;
      next_r    <= 2'd0;
      count_r   <= CNT_0;
      pending_r <= 4'b0000;
      lights_r  <= 8'b00_00_00_10;
      grant_r   <= 4'b0001;
      phase_r   <= 2'd0;
    end else begin
      state_r   <= state_n_s;
      cur_r     <= cur_n_s;
      next_r    <= next_n_s;
      count_r   <= count_n_s;
      pending_r <= pending_n_s;
      lights_r  <= lights_n_s;
      grant_r   <= grant_n_s;
      phase_r   <= phase_n_s;
    end
  end

  assign lights = lights_r;
  assign grant  = grant_r;
  assign phase  = phase_r;

endmodule

// File: tb/tb_light_phase_arbiter.sv
// Scoreboard bench for light_phase_arbiter: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_light_phase_arbiter;

  logic       clk     = 1'b0;
  logic       clear_n = 1'b1;
  logic [3:0] req     = 4'b0000;
  logic [7:0] lights;
  logic [3:0] grant;
  logic [1:0] phase;

  int cyc   = 0;
  int base  = 0;
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] l;
    logic [3:0] g;
    logic [1:0] p;
  } exp_t;

  exp_t sb_q[$];

  light_phase_arbiter #(
    .GREEN_MIN (4),
    .GREEN_MAX (8),
    .YELLOW_T  (2),
    .ALLRED_T  (1)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .req     (req),
    .lights  (lights),
    .grant   (grant),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc - base, act, req_v);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   nr;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_check abs_cyc=%0d actual=none required=checked", e.cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      chk("lights", lights, e.l);
      chk("grant", {4'b0000, grant}, {4'b0000, e.g});
      chk("phase", {6'b000000, phase}, {6'b000000, e.p});
    end
    if (chk_en) begin
      nr = 0;
      for (int i = 0; i < 4; i++) begin
        if (lights[2*i +: 2] != 2'd0) nr++;
        if (lights[2*i +: 2] == 2'd3) nr = nr + 8;
      end
      chk("single_live", {7'b0000000, (nr <= 1)}, 8'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input int start, input int len, input logic [7:0] l,
                          input logic [3:0] g, input logic [1:0] p);
    for (int i = 0; i < len; i++) begin
      sb_q.push_back('{base + start + i, l, g, p});
    end
  endtask

  // Assert clear_n for one cycle; outputs must show the reset state at once.
  task automatic do_reset();
    clear_n = 1'b0;
    req     = 4'b0000;
    chk_en  = 1'b1;
    sb_q.push_back('{cyc, 8'h02, 4'b0001, 2'd0});
    tick(1);
    clear_n = 1'b1;
    base    = cyc;
  endtask

  task automatic run(input logic [3:0] first, input logic [3:0] hold, input int ncyc);
    req = first;
    tick(1);
    req = hold;
    tick(ncyc - 1);
  endtask

  initial begin
    tick(1);

    // Idle: approach 0 rests GREEN.
    do_reset();
    push_seg(0, 30, 8'h02, 4'b0001, 2'd0);
    run(4'b0000, 4'b0000, 30);

    // Single pulse on approach 2 right after reset.
    do_reset();
    push_seg(0, 4, 8'h02, 4'b0001, 2'd0);
    push_seg(4, 2, 8'h01, 4'b0001, 2'd1);
    push_seg(6, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(7, 10, 8'h20, 4'b0100, 2'd0);
    run(4'b0100, 4'b0000, 17);

    // Approaches 1 and 3 together: order 0,1,3 then 3 holds.
    do_reset();
    push_seg(0, 4, 8'h02, 4'b0001, 2'd0);
    push_seg(4, 2, 8'h01, 4'b0001, 2'd1);
    push_seg(6, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(7, 4, 8'h08, 4'b0010, 2'd0);
    push_seg(11, 2, 8'h04, 4'b0010, 2'd1);
    push_seg(13, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(14, 10, 8'h80, 4'b1000, 2'd0);
    run(4'b1010, 4'b0000, 24);

    // Highway held busy: max-out at 8 cycles, then back to 0 after approach 1.
    do_reset();
    push_seg(0, 8, 8'h02, 4'b0001, 2'd0);
    push_seg(8, 2, 8'h01, 4'b0001, 2'd1);
    push_seg(10, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(11, 4, 8'h08, 4'b0010, 2'd0);
    push_seg(15, 2, 8'h04, 4'b0010, 2'd1);
    push_seg(17, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(18, 8, 8'h02, 4'b0001, 2'd0);
    run(4'b0011, 4'b0001, 26);

    // All approaches busy: full rotation, each GREEN maxes out.
    do_reset();
    for (int a = 0; a < 4; a++) begin
      push_seg(11*a, 8, 8'h02 << (2*a), 4'b0001 << a, 2'd0);
      push_seg(11*a + 8, 2, 8'h01 << (2*a), 4'b0001 << a, 2'd1);
      push_seg(11*a + 10, 1, 8'h00, 4'b0000, 2'd2);
    end
    push_seg(44, 8, 8'h02, 4'b0001, 2'd0);
    run(4'b1111, 4'b1111, 52);

    // Reset during YELLOW of approach 1 drops the pending request for 2.
    do_reset();
    push_seg(0, 4, 8'h02, 4'b0001, 2'd0);
    push_seg(4, 2, 8'h01, 4'b0001, 2'd1);
    push_seg(6, 1, 8'h00, 4'b0000, 2'd2);
    push_seg(7, 4, 8'h08, 4'b0010, 2'd0);
    run(4'b0110, 4'b0000, 11);
    do_reset();
    push_seg(0, 20, 8'h02, 4'b0001, 2'd0);
    tick(20);

    tick(3);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
